sample_pwm_dac: RTL and testbench

SAMPLE_PWM_DAC -- requirements
Module: sample_pwm_dac

---
 rtl/sample_pwm_dac.sv | 102 ++++++++++
 tb/tb_sample_pwm_dac.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pwm_dac.sv
// sample_pwm_dac: 8-bit, 256-cycle-frame PWM audio DAC.
// Requests one sample per frame from the upstream sound path, buffers it in
// a one-deep pending slot, and swaps it into the active duty only at the
// frame boundary so the duty never changes mid-frame.
module sample_pwm_dac #(
    parameter bit SAT = 1'b1  // 1: clamp samples above 255; 0: use sample[8:1]
) (
    input  logic       clk,
    input  logic       n_rst,       // synchronous, active-high
    input  logic       en,
    input  logic [8:0] sample,
    input  logic       ready,
    input  logic       ovr_clr,
    output logic       sample_now,
    output logic       pwm_o,
    output logic       overrun
);

    logic [7:0] cnt_q,        cnt_d;
    logic [7:0] active_q,     active_d;
    logic [7:0] pend_q,       pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic       sample_now_q, sample_now_d;
    logic       pwm_q,        pwm_d;
    logic       overrun_q,    overrun_d;

    logic [7:0] duty_conv;
    logic       boundary;

    // Map the 9-bit sample onto the 8-bit duty range.
    always_comb begin
        if (SAT) begin
            duty_conv = sample[8] ? 8'hFF : sample[7:0];
        end else begin
            duty_conv = sample[8:1];
        end
    end

    // Last cycle of a frame: the only point where the active duty may change.
    assign boundary = en && (cnt_q == 8'd255);

    // Next-state logic for the counter, sample buffer, flags and PWM output.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        cnt_d        = en ? cnt_q + 8'd1 : 8'd0;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        sample_now_d = boundary;
        pwm_d        = en && (cnt_q < active_q);
        overrun_d    = overrun_q;

        // Frame boundary consumes the pending sample; a sample arriving in
        // the same cycle refills the slot below without counting as overrun.
        if (boundary && pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
        end

        if (ready) begin
            pend_d       = duty_conv;
            pend_valid_d = 1'b1;
        end

        // Set wins over clear so a simultaneous overrun is never lost.
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (ready && pend_valid_q && !boundary) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with synchronous reset that overrides all inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (n_rst) begin
            cnt_q        <= 8'd0;
            active_q     <= 8'd0;
            pend_q       <= 8'd0;
            pend_valid_q <= 1'b0;
            sample_now_q <= 1'b0;
            pwm_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            sample_now_q <= sample_now_d;
            pwm_q        <= pwm_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample_now = sample_now_q;
    assign pwm_o      = pwm_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_pwm_dac.sv
// Directed testbench for sample_pwm_dac. Two instances share all inputs:
// dut_sat (SAT=1) and dut_div (SAT=0). Outputs are read on the falling
// edge, and inputs are changed on that same falling edge after the read.
module tb_sample_pwm_dac;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [8:0] sample;
    logic       ready;
    logic       ovr_clr;

    logic       sn1, pwm1, ovr1;
    logic       sn0, pwm0, ovr0;

    int vectors;
    int miscompares;

    sample_pwm_dac #(.SAT(1'b1)) dut_sat (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .sample     (sample),
        .ready      (ready),
        .ovr_clr    (ovr_clr),
        .sample_now (sn1),
        .pwm_o      (pwm1),
        .overrun    (ovr1)
    );

    sample_pwm_dac #(.SAT(1'b0)) dut_div (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .sample     (sample),
        .ready      (ready),
        .ovr_clr    (ovr_clr),
        .sample_now (sn0),
        .pwm_o      (pwm0),
        .overrun    (ovr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the first cycle of a frame (the cycle where sample_now is 1).
    task automatic wait_frame_start(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (sn1 !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sn1 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: frame start timeout, sample_now=%b expected 1", name, sn1);
        end
    endtask

    // Called at the frame-start cycle. Observes the 256 PWM outputs of that
    // frame; pwm must be high exactly for the first exp cycles. Optional
    // ready pulses are injected during the frame at indices ia/ib
    // (index 254 is the boundary cycle). Ends at the next frame start.
    task automatic measure_frame(input string name,
                                 input int ia, input logic [8:0] sa,
                                 input int ib, input logic [8:0] sb,
                                 input int exp1, input int exp0);
        int bad1, bad0, hi1, hi0;
        bad1 = 0; bad0 = 0; hi1 = 0; hi0 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm1 === 1'b1) hi1++;
            if (pwm0 === 1'b1) hi0++;
            if (pwm1 !== ((i < exp1) ? 1'b1 : 1'b0)) bad1++;
            if (pwm0 !== ((i < exp0) ? 1'b1 : 1'b0)) bad0++;
            if (i == ia) begin
                ready = 1'b1; sample = sa;
            end else if (i == ib) begin
                ready = 1'b1; sample = sb;
            end else begin
                ready = 1'b0;
            end
        end
        ready = 1'b0;
        vectors += 2;
        if (bad1 != 0) begin
            miscompares++;
            $display("FAIL %s sat1: high=%0d badcycles=%0d expected %0d contiguous high", name, hi1, bad1, exp1);
        end
        if (bad0 != 0) begin
            miscompares++;
            $display("FAIL %s sat0: high=%0d badcycles=%0d expected %0d contiguous high", name, hi0, bad0, exp0);
        end
    endtask

    task automatic check_overrun(input string name, input logic exp);
        vectors++;
        if (ovr1 !== exp || ovr0 !== exp) begin
            miscompares++;
            $display("FAIL %s: overrun sat1=%b sat0=%b expected %b", name, ovr1, ovr0, exp);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1; en = 1'b1; ready = 1'b1; sample = 9'd300; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sn1, pwm1, ovr1, sn0, pwm0, ovr0} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000", {sn1, pwm1, ovr1, sn0, pwm0, ovr0});
        end
        n_rst = 1'b0; en = 1'b0; ready = 1'b0;
        @(negedge clk);
    endtask

    // en held high for 1024+ cycles: pulses at 256, 512, 768, 1024; pwm low.
    task automatic test_frame_timing();
        int pulses, misplaced, pwm_hi;
        pulses = 0; misplaced = 0; pwm_hi = 0;
        en = 1'b1;
        for (int t = 1; t <= 1030; t++) begin
            @(negedge clk);
            if (sn1 === 1'b1) pulses++;
            if (sn1 !== (((t % 256) == 0) ? 1'b1 : 1'b0)) misplaced++;
            if (pwm1 !== 1'b0 || pwm0 !== 1'b0) pwm_hi++;
        end
        vectors += 3;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL frame_pulse_count: got %0d expected 4", pulses);
        end
        if (misplaced != 0) begin
            miscompares++;
            $display("FAIL frame_pulse_spacing: %0d misplaced cycles expected 0", misplaced);
        end
        if (pwm_hi != 0) begin
            miscompares++;
            $display("FAIL frame_pwm_idle: %0d high cycles expected 0", pwm_hi);
        end
    endtask

    task automatic test_duty_update();
        wait_frame_start("duty_sync");
        measure_frame("duty_current_unchanged", 50, 9'd100, -1, 9'd0, 0, 0);
        measure_frame("duty_100", -1, 9'd0, -1, 9'd0, 100, 50);
        measure_frame("duty_repeat", -1, 9'd0, -1, 9'd0, 100, 50);
        check_overrun("duty_no_overrun", 1'b0);
    endtask

    task automatic test_saturation();
        measure_frame("sat_pre", 10, 9'd400, -1, 9'd0, 100, 50);
        measure_frame("sat_400", -1, 9'd0, -1, 9'd0, 255, 200);
    endtask

    task automatic test_overrun();
        measure_frame("ovr_two_pulses", 20, 9'd50, 120, 9'd80, 255, 200);
        check_overrun("ovr_set", 1'b1);
        measure_frame("ovr_newest_wins", -1, 9'd0, -1, 9'd0, 80, 40);
        check_overrun("ovr_sticky", 1'b1);
        // at frame start (cnt=0): clear
        ovr_clr = 1'b1;
        @(negedge clk);
        check_overrun("ovr_cleared", 1'b0);
        ovr_clr = 1'b0; ready = 1'b1; sample = 9'd80;
        @(negedge clk);
        ovr_clr = 1'b1;                     // second ready plus clear: set wins
        @(negedge clk);
        check_overrun("ovr_set_beats_clr", 1'b1);
        ready = 1'b0;                       // ovr_clr still 1: clears now
        @(negedge clk);
        check_overrun("ovr_cleared_again", 1'b0);
        ovr_clr = 1'b0;
        wait_frame_start("ovr_sync");
        measure_frame("ovr_pend_80", -1, 9'd0, -1, 9'd0, 80, 40);
    endtask

    task automatic test_back_to_back();
        measure_frame("b2b_load", 100, 9'd60, 254, 9'd90, 80, 40);
        check_overrun("b2b_boundary_no_overrun", 1'b0);
        measure_frame("b2b_old_pend", -1, 9'd0, -1, 9'd0, 60, 30);
        measure_frame("b2b_new_pend", -1, 9'd0, -1, 9'd0, 90, 45);
        check_overrun("b2b_still_clear", 1'b0);
    endtask

    task automatic test_enable_gap();
        int bad, t;
        bad = 0;
        repeat (100) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm1 !== 1'b0 || pwm0 !== 1'b0 || sn1 !== 1'b0 || sn0 !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL gap_outputs_low: %0d active cycles expected 0", bad);
        end
        en = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sn1 !== 1'b1 && t < 300);
        vectors++;
        if (t != 256) begin
            miscompares++;
            $display("FAIL gap_restart: sample_now after %0d cycles expected 256", t);
        end
        measure_frame("gap_duty_retained", -1, 9'd0, -1, 9'd0, 90, 45);
    endtask

    task automatic test_reset_midframe();
        int t;
        repeat (77) @(negedge clk);
        n_rst = 1'b1; ready = 1'b1; sample = 9'd200; ovr_clr = 1'b0;
        @(negedge clk);
        n_rst = 1'b0; ready = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sn1 !== 1'b1 && t < 300);
        vectors++;
        if (t != 256) begin
            miscompares++;
            $display("FAIL rst_mid_restart: sample_now after %0d cycles expected 256", t);
        end
        measure_frame("rst_mid_duty_zero", -1, 9'd0, -1, 9'd0, 0, 0);
        check_overrun("rst_mid_no_overrun", 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n_rst = 1'b1; en = 1'b0; sample = 9'd0; ready = 1'b0; ovr_clr = 1'b0;
        test_reset();
        test_frame_timing();
        test_duty_update();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_enable_gap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
